// File: rtl/mc_control_fsm.sv
// Multicycle-datapath sequencing FSM: per-state mux selects and write enables,
// stalls in FETCH/MEMREAD/MEMWRITE until the shared memory signals mem_ready.
module mc_control_fsm #(
  parameter int NUM_STATES = 11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] Op,
  input  logic [5:0] Funct,
  input  logic [3:0] Rd,
  input  logic       CondEx,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       IRWrite,
  output logic       AdrSrc,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic       ALUOp,
  output logic       PCWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic       linkSelect,
  output logic       illegal,
  output logic       instr_done,
  output logic [3:0] state
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_ILLEGAL  = 4'd10
  } state_t;

  state_t state_q, state_d;

  logic       mem_req_c, irw_c, adr_c, srca_c, aluop_c, pcw_c, rw_c, mw_c;
  logic       lnk_c, ill_c, done_c;
  logic [1:0] srcb_c, res_c;
  logic       state_legal, out_en;
  logic       rd_is_pc;
  logic       unused_funct;

  assign rd_is_pc     = (Rd == 4'hF);
  assign unused_funct = ^Funct[2:1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_req_c = 1'b0;
    irw_c     = 1'b0;
    adr_c     = 1'b0;
    srca_c    = 1'b0;
    srcb_c    = 2'b00;
    res_c     = 2'b00;
    aluop_c   = 1'b0;
    pcw_c     = 1'b0;
    rw_c      = 1'b0;
    mw_c      = 1'b0;
    lnk_c     = 1'b0;
    ill_c     = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      S_FETCH: begin
        mem_req_c = 1'b1;
        srca_c    = 1'b1;
        srcb_c    = 2'b10;
        res_c     = 2'b10;
        irw_c     = mem_ready;
        pcw_c     = mem_ready;
        if (mem_ready) state_d = S_DECODE;
      end
      S_DECODE: begin
        srca_c = 1'b1;
        srcb_c = 2'b10;
        res_c  = 2'b10;
        if (!CondEx) begin
          state_d = S_FETCH;
          done_c  = 1'b1;
        end else begin
          case (Op)
            2'b00:   state_d = Funct[5] ? S_EXECI : S_EXECR;
            2'b01:   state_d = S_MEMADR;
            2'b10:   state_d = S_BRANCH;
            default: state_d = S_ILLEGAL;
          endcase
        end
      end
      S_MEMADR: begin
        srcb_c  = 2'b01;
        state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req_c = 1'b1;
        adr_c     = 1'b1;
        if (mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        res_c   = 2'b01;
        rw_c    = 1'b1;
        pcw_c   = rd_is_pc;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_MEMWRITE: begin
        // Strobe is held for the whole access; the memory samples it with mem_ready.
        mem_req_c = 1'b1;
        adr_c     = 1'b1;
        mw_c      = 1'b1;
        if (mem_ready) begin
          done_c  = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_EXECR: begin
        aluop_c = 1'b1;
        state_d = S_ALUWB;
      end
      S_EXECI: begin
        srcb_c  = 2'b01;
        aluop_c = 1'b1;
        state_d = S_ALUWB;
      end
      S_ALUWB: begin
        aluop_c = 1'b1;
        rw_c    = (Funct[4:3] != 2'b10);
        pcw_c   = rw_c & rd_is_pc;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_BRANCH: begin
        srcb_c  = 2'b01;
        res_c   = 2'b10;
        pcw_c   = 1'b1;
        lnk_c   = Funct[4];
        rw_c    = Funct[4];
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      S_ILLEGAL: begin
        ill_c   = 1'b1;
        done_c  = 1'b1;
        state_d = S_FETCH;
      end
      default: state_d = S_FETCH;
    endcase
  end

  // Reset gates the outputs combinationally so an in-flight write is cut at the reset edge.
  assign state_legal = ({28'd0, state_q} < 32'(NUM_STATES));
  assign out_en      = reset & state_legal;

  assign mem_req    = out_en & mem_req_c;
  assign IRWrite    = out_en & irw_c;
  assign AdrSrc     = out_en & adr_c;
  assign ALUSrcA    = out_en & srca_c;
  assign ALUSrcB    = out_en ? srcb_c : 2'b00;
  assign ResultSrc  = out_en ? res_c : 2'b00;
  assign ALUOp      = out_en & aluop_c;
  assign PCWrite    = out_en & pcw_c;
  assign RegWrite   = out_en & rw_c;
  assign MemWrite   = out_en & mw_c;
  assign linkSelect = out_en & lnk_c;
  assign illegal    = out_en & ill_c;
  assign instr_done = out_en & done_c;
  assign state      = out_en ? state_q : 4'd0;

endmodule

// File: doc/mc_control_fsm.md
Name: mc_control_fsm

Overview:
- Main sequencing FSM for the multicycle datapath: generates per-cycle mux selects and write enables (AdrSrc, ALUSrcA, ALUSrcB, ResultSrc, IRWrite, PCWrite, RegWrite, MemWrite, linkSelect).
- Sits beside the datapath and the ALU/shift decoder.
- Uses a req/ready handshake with a shared instruction/data memory, which may stall.

Parameters:
- NUM_STATES, 11, number of encoded states (informational; state register is 4 bits).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- Op  input  2  Instr[27:26]
- Funct  input  6  Instr[25:20] (I, opcode[3:0], S/L)
- Rd  input  4  Instr[15:12]
- CondEx  input  1  condition check passed (valid in DECODE)
- mem_ready  input  1  memory completed the current access this cycle
- mem_req  output  1  memory access request
- IRWrite  output  1  latch instruction register
- AdrSrc  output  1  0=PC, 1=ALUOut
- ALUSrcA  output  1  0=RD1, 1=PC
- ALUSrcB  output  2  00=RD2, 01=ExtImm, 10=const 4
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUOp  output  1  1=decode Funct for ALUControl, 0=add
- PCWrite  output  1  PC register enable
- RegWrite  output  1  register file write enable
- MemWrite  output  1  memory write strobe
- linkSelect  output  1  BL: write PC+4 to R14
- illegal  output  1  one-cycle pulse on Op=11
- instr_done  output  1  one-cycle pulse on the last cycle of each instruction
- state  output  4  current state (debug)

Behaviour:
- States: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECR=6, EXECI=7, ALUWB=8, BRANCH=9, ILLEGAL=10.
- Reset (reset=0, async): state=FETCH; every output is 0 while reset is low. In the first cycle after deassertion, FETCH outputs are driven.
- FETCH outputs: mem_req=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10. IRWrite=PCWrite=mem_ready. Goes to DECODE when mem_ready=1; otherwise holds with no IR or PC update.
- DECODE outputs: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, all enables 0.
- DECODE transitions:
  - CondEx=0: FETCH, with instr_done=1.
  - Op=01: MEMADR.
  - Op=00 and Funct[5]=0: EXECR.
  - Op=00 and Funct[5]=1: EXECI.
  - Op=10: BRANCH.
  - Op=11: ILLEGAL.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUOp=0. Goes to MEMREAD if Funct[0]=1, else MEMWRITE.
- MEMREAD: mem_req=1, AdrSrc=1, ResultSrc=00. Goes to MEMWB when mem_ready=1; otherwise holds.
- MEMWRITE: mem_req=1, AdrSrc=1, MemWrite=1 for every cycle until mem_ready. Goes to FETCH when mem_ready=1, with instr_done=1.
- MEMWB: ResultSrc=01, RegWrite=1, PCWrite=(Rd==4'hF). Goes to FETCH with instr_done=1.
- EXECR: ALUSrcA=0, ALUSrcB=00, ALUOp=1. Goes to ALUWB.
- EXECI: ALUSrcA=0, ALUSrcB=01, ALUOp=1. Goes to ALUWB.
- ALUWB: ResultSrc=00, ALUOp=1.
  - RegWrite=1 unless Funct[4:3]==2'b10 (TST/TEQ/CMP/CMN), which gives RegWrite=0.
  - PCWrite=RegWrite&(Rd==4'hF).
  - Goes to FETCH with instr_done=1.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=1. linkSelect=RegWrite=Funct[4] (L bit). Goes to FETCH with instr_done=1.
- ILLEGAL: illegal=1 and instr_done=1, no writes. Goes to FETCH.
- Outputs are Moore, except the mem_ready-qualified IRWrite/PCWrite in FETCH and the Rd/Funct-qualified enables.
- Inputs are not registered inside the block; the datapath IR holds Op/Funct/Rd stable after FETCH.
- Unused encodings 11..15 go to FETCH with all outputs 0.
- mem_ready is ignored outside FETCH, MEMREAD and MEMWRITE.
- Reset asserted mid-instruction aborts immediately. No partial write is issued after the reset edge.

Test Plan:
- Reset low for 3 cycles, then release with mem_ready=1:
  - All outputs 0 during reset.
  - Cycle 1 after release: state=0, mem_req=1, IRWrite=1, PCWrite=1.
- ADD register form (Op=00, Funct=6'b001000, Rd=3, CondEx=1, mem_ready=1):
  - States 0→1→6→8→0.
  - RegWrite=1 only in ALUWB; instr_done pulses there.
- LDR (Op=01, Funct[0]=1, Rd=15) with mem_ready held low 2 cycles in FETCH and 3 cycles in MEMREAD:
  - FETCH held 3 cycles with IRWrite=0 until the ready cycle.
  - MEMREAD held 4 cycles.
  - MEMWB asserts RegWrite=1 and PCWrite=1.
- STR (Funct[0]=0) with 2 wait cycles:
  - MemWrite=1 for 3 consecutive cycles in MEMWRITE, then FETCH.
  - RegWrite never asserted.
- BL (Op=10, Funct[4]=1) -> BRANCH asserts PCWrite=1, linkSelect=1, RegWrite=1. B (Funct[4]=0) -> linkSelect=0, RegWrite=0.
- Boundary cases:
  - CMP (Funct[4:3]=10, Rd=15) -> ALUWB with RegWrite=0, PCWrite=0.
  - CondEx=0 in DECODE -> FETCH next cycle, instr_done=1.
  - Op=11 -> ILLEGAL, illegal=1 for exactly one cycle.
  - reset pulsed low during MEMWRITE -> MemWrite drops to 0 asynchronously; state=0.
